bit_permute_unit: RTL and testbench

- Parametrised, pipelined successor to the fixed 8-bit bit-reversal wiring block.
- Applies a run-time-selectable bit permutation to a WIDTH-bit word: pass, full reverse, byte swap, rotate left/right, per-byte reverse.
- Two-stage registered datapath with valid/ready handshakes on both sides.
- Sits between a producer (register file or bus) and a consumer inside the SCM16 datapath.

---
 rtl/bit_permute_pkg.sv | 13 +
 rtl/bit_permute_core.sv | 63 ++++++
 rtl/bit_permute_unit.sv | 88 ++++++++
 tb/tb_bit_permute_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/bit_permute_pkg.sv
// Shared types and mode encodings for the bit permutation unit.
package bit_permute_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_PASS  = 3'd0;
  localparam mode_t MODE_REV   = 3'd1;
  localparam mode_t MODE_BSWAP = 3'd2;
  localparam mode_t MODE_ROTL  = 3'd3;
  localparam mode_t MODE_ROTR  = 3'd4;
  localparam mode_t MODE_BREV8 = 3'd5;

endpackage

// File: rtl/bit_permute_core.sv
// Combinational bit permutation: reverse, byte swap, rotates and per-byte reverse.
module bit_permute_core
  import bit_permute_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  mode_t            mode_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  localparam int unsigned NBYTES = WIDTH / 8;

  logic [31:0]      sh;
  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] bswap;
  logic [WIDTH-1:0] brev8;
  logic [WIDTH-1:0] rotl;
  logic [WIDTH-1:0] rotr;

  // Non-power-of-two widths can present amounts >= WIDTH.
  assign sh = 32'(amt_i) % WIDTH;

  // A shift by WIDTH yields zero, so amount 0 reduces to the operand itself.
  assign rotl = (data_i << sh) | (data_i >> (WIDTH - sh));
  assign rotr = (data_i >> sh) | (data_i << (WIDTH - sh));

  always_comb begin
    rev   = '0;
    bswap = '0;
    brev8 = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      rev[i] = data_i[int'(WIDTH) - 1 - i];
    end
    for (int k = 0; k < int'(NBYTES); k++) begin
      bswap[8*(int'(NBYTES) - 1 - k) +: 8] = data_i[8*k +: 8];
      for (int b = 0; b < 8; b++) begin
        brev8[8*k + b] = data_i[8*k + 7 - b];
      end
    end
  end

  always_comb begin
    result_o = data_i;
    err_o    = 1'b0;
    case (mode_i)
      MODE_PASS:  result_o = data_i;
      MODE_REV:   result_o = rev;
      MODE_BSWAP: result_o = bswap;
      MODE_ROTL:  result_o = rotl;
      MODE_ROTR:  result_o = rotr;
      MODE_BREV8: result_o = brev8;
      default: begin
        result_o = data_i;
        err_o    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/bit_permute_unit.sv
// Two-stage valid/ready pipeline around bit_permute_core.
module bit_permute_unit
  import bit_permute_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  mode_t            in_mode,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  if ((WIDTH < 8) || ((WIDTH % 8) != 0)) begin : gen_width_check
    $error("bit_permute_unit: WIDTH must be a multiple of 8 and at least 8");
  end

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  mode_t            s1_mode_q;
  logic [AMT_W-1:0] s1_amt_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_data_q;
  logic             s2_err_q;

  logic [WIDTH-1:0] core_result;
  logic             core_err;
  logic             s1_adv;
  logic             s2_adv;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  bit_permute_core #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_core (
    .data_i   (s1_data_q),
    .mode_i   (s1_mode_q),
    .amt_i    (s1_amt_q),
    .result_o (core_result),
    .err_o    (core_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        // Keep the last result when S1 is empty; it is unqualified anyway.
        if (s1_valid_q) begin
          s2_data_q <= core_result;
          s2_err_q  <= core_err;
        end
      end
    end
  end

  // Operand registers need no reset: they are only consumed behind s1_valid_q.
  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      s1_data_q <= in_data;
      s1_mode_q <= in_mode;
      s1_amt_q  <= in_amt;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;

endmodule

// File: tb/tb_bit_permute_unit.sv
// Directed bench for bit_permute_unit at WIDTH=16 with hand-computed results.
module tb_bit_permute_unit;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned AMT_W = 4;
  localparam int NVEC = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_mode;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  int checks = 0;
  int errors = 0;

  logic [2:0]  v_mode [NVEC] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd3, 3'd4, 3'd6, 3'd0, 3'd7};
  logic [3:0]  v_amt  [NVEC] = '{4'd0, 4'd0, 4'd4, 4'd4, 4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 4'd9};
  logic [15:0] v_data [NVEC] = '{16'h0001, 16'h1234, 16'h1234, 16'h1234, 16'h0180,
                                 16'hBEEF, 16'h8001, 16'hA5A5, 16'h0F0F, 16'h1234};
  logic [15:0] v_exp  [NVEC] = '{16'h8000, 16'h3412, 16'h2341, 16'h4123, 16'h8001,
                                 16'hBEEF, 16'h0003, 16'hA5A5, 16'h0F0F, 16'h1234};
  logic        v_err  [NVEC] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  bit_permute_unit #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [3:0] a,
                       input logic [15:0] d);
    in_valid = v;
    in_mode  = m;
    in_amt   = a;
    in_data  = d;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 4'd0, 16'h0000);
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'h0000);
    chk("reset_out_err", 32'(out_err), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back stream; each result appears right after the edge following its input edge.
    for (int i = 0; i <= NVEC; i++) begin
      if (i < NVEC) drive(1'b1, v_mode[i], v_amt[i], v_data[i]);
      else drive(1'b0, 3'd0, 4'd0, 16'h0000);
      #1;
      chk($sformatf("stream_in_ready_%0d", i), 32'(in_ready), 32'd1);
      cyc();
      if (i == 0) begin
        chk("first_latency_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk($sformatf("stream_valid_%0d", i - 1), 32'(out_valid), 32'd1);
        chk($sformatf("stream_data_%0d", i - 1), 32'(out_data), 32'(v_exp[i - 1]));
        chk($sformatf("stream_err_%0d", i - 1), 32'(out_err), 32'(v_err[i - 1]));
      end
    end
    drive(1'b0, 3'd0, 4'd0, 16'h0000);
    cyc();
    chk("drained_out_valid", 32'(out_valid), 32'd0);

    // Backpressure: three words with the consumer stalled.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 4'd0, 16'h1111);
    cyc();
    chk("bp_ready_after_1", 32'(in_ready), 32'd1);
    drive(1'b1, 3'd1, 4'd0, 16'h0001);
    cyc();
    chk("bp_ready_after_2", 32'(in_ready), 32'd0);
    chk("bp_valid_a", 32'(out_valid), 32'd1);
    chk("bp_data_a", 32'(out_data), 32'h1111);
    drive(1'b1, 3'd2, 4'd0, 16'hABCD);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("bp_hold_data_%0d", k), 32'(out_data), 32'h1111);
      chk($sformatf("bp_hold_ready_%0d", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    cyc();
    drive(1'b0, 3'd0, 4'd0, 16'h0000);
    chk("bp_valid_b", 32'(out_valid), 32'd1);
    chk("bp_data_b", 32'(out_data), 32'h8000);
    cyc();
    chk("bp_valid_c", 32'(out_valid), 32'd1);
    chk("bp_data_c", 32'(out_data), 32'hCDAB);
    cyc();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with both stages full and the consumer stalled.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 4'd0, 16'h5555);
    cyc();
    drive(1'b1, 3'd0, 4'd0, 16'h6666);
    cyc();
    chk("mid_full_ready", 32'(in_ready), 32'd0);
    chk("mid_full_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 3'd0, 4'd0, 16'h0000);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_data", 32'(out_data), 32'h0000);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("mid_no_stale_%0d", k), 32'(out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
